// File: rtl/srff_drv_pkg.sv
// Shared definitions for the SR flip-flop command driver: FSM encodings
// and the skip counter width/saturation helper.
package srff_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int unsigned       SKIP_W   = 8;
  localparam logic [SKIP_W-1:0] SKIP_MAX = '1;

  // Increment that sticks at SKIP_MAX.
  function automatic logic [SKIP_W-1:0] skip_sat_inc(input logic [SKIP_W-1:0] v);
    return (v == SKIP_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous 1-bit-wide request FIFO. The head entry is visible
// combinationally on dout; push and pop may occur on the same edge.
module req_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   din,
  input  logic                   pop,
  output logic                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/srff_driver.sv
// Command-side driver for an SR flip-flop: queues requested levels and
// issues registered, mutually exclusive s/r pulses separated by an idle gap,
// skipping requests that match the shadow flip-flop state.
module srff_driver
  import srff_drv_pkg::*;
#(
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned GAP     = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_level,
  output logic              req_ready,
  output logic              s,
  output logic              r,
  output logic              q_model,
  output logic              busy,
  output logic [SKIP_W-1:0] skip_cnt
);

  localparam int unsigned CNT_MAX = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP != 0) ? CW'(GAP - 1) : '0;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                s_q, s_d;
  logic                r_q, r_d;
  logic                qm_q, qm_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;

  logic                pop;
  logic                head;
  logic                full;
  logic                empty;
  logic [$clog2(DEPTH):0] count;

  req_fifo #(
    .DEPTH(DEPTH)
  ) u_req_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (req_valid && req_ready),
    .din  (req_level),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  // State register plus the registered pulse outputs, shadow and counters;
  // async reset drops s/r immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      qm_q    <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      qm_q    <= qm_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!empty && (head != qm_q)) state_d = ST_PULSE;
      ST_PULSE: if (cnt_q == '0) state_d = (GAP != 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (cnt_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pop decision, pulse levels, shadow update and counter loads.
  // s/r, q_model and the counter are all computed here so the pulse start
  // and the shadow change land on the same edge.
  always_comb begin
    pop    = 1'b0;
    cnt_d  = cnt_q;
    s_d    = s_q;
    r_d    = r_q;
    qm_d   = qm_q;
    skip_d = skip_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head == qm_q) begin
            skip_d = skip_sat_inc(skip_q);
          end else begin
            s_d   = head;
            r_d   = ~head;
            qm_d  = head;
            cnt_d = PULSE_LOAD;
          end
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          s_d   = 1'b0;
          r_d   = 1'b0;
          cnt_d = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      default: begin
        s_d = 1'b0;
        r_d = 1'b0;
      end
    endcase
  end

  assign s         = s_q;
  assign r         = r_q;
  assign q_model   = qm_q;
  assign skip_cnt  = skip_q;
  assign req_ready = ~full;
  assign busy      = (state_q != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_srff_driver.sv
// Directed bench for srff_driver: default instance (PULSE_W=1, GAP=2,
// DEPTH=4) and a PULSE_W=3 instance for the mid-pulse reset scenario.
module tb_srff_driver;

  logic       clk;
  logic       rst, req_valid, req_level;
  logic       req_ready, s, r, q_model, busy;
  logic [7:0] skip_cnt;

  logic       rst3, req_valid3, req_level3;
  logic       req_ready3, s3, r3, q_model3, busy3;
  logic [7:0] skip_cnt3;

  int checks = 0;
  int errors = 0;

  srff_driver #(.PULSE_W(1), .GAP(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_level(req_level),
    .req_ready(req_ready), .s(s), .r(r), .q_model(q_model), .busy(busy),
    .skip_cnt(skip_cnt)
  );

  srff_driver #(.PULSE_W(3), .GAP(2), .DEPTH(4)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_level(req_level3),
    .req_ready(req_ready3), .s(s3), .r(r3), .q_model(q_model3), .busy(busy3),
    .skip_cnt(skip_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    check1("s_r_exclusive", s && r, 1'b0);
    check1("s3_r3_exclusive", s3 && r3, 1'b0);
  end

  initial begin
    int   idx, acc_at_full, npulses, idle_run, min_gap, hi_run, bad_len;
    int   accepted, pulses;
    logic prev, act, pre_ready, seen_full;
    logic [5:0] plv;

    rst = 1'b1; req_valid = 1'b0; req_level = 1'b0;
    rst3 = 1'b1; req_valid3 = 1'b0; req_level3 = 1'b0;
    tick(); tick();
    check1("rst_s", s, 1'b0);
    check1("rst_r", r, 1'b0);
    check1("rst_qmodel", q_model, 1'b0);
    check32("rst_skip", 32'(skip_cnt), 0);
    rst = 1'b0; rst3 = 1'b0;
    tick();
    check1("post_rst_ready", req_ready, 1'b1);
    check1("post_rst_busy", busy, 1'b0);

    // Single set request: s high for one cycle starting at edge N+1.
    req_valid = 1'b1; req_level = 1'b1;
    tick();                                   // edge N accepts
    req_valid = 1'b0;
    check1("set_s_before", s, 1'b0);
    tick();                                   // N+1
    check1("set_s_high", s, 1'b1);
    check1("set_r_low", r, 1'b0);
    check1("set_qmodel", q_model, 1'b1);
    check1("set_busy_n1", busy, 1'b1);
    tick();                                   // N+2
    check1("set_s_low", s, 1'b0);
    check1("set_busy_n2", busy, 1'b1);
    tick();                                   // N+3
    check1("set_busy_n3", busy, 1'b1);
    tick();                                   // N+4
    check1("set_busy_n4", busy, 1'b0);

    // Redundant set request: skipped, no pulse.
    req_valid = 1'b1; req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check1("skip_s", s, 1'b0);
    check32("skip_cnt_1", 32'(skip_cnt), 1);
    tick();
    check1("skip_busy", busy, 1'b0);
    check1("skip_r", r, 1'b0);

    // Back-to-back alternating requests 0,1,0,1,0,1 with valid held.
    idx = 0; acc_at_full = -1; seen_full = 1'b0;
    npulses = 0; idle_run = 0; min_gap = 1000; hi_run = 0; bad_len = 0;
    prev = 1'b0; plv = '0;
    for (int c = 0; c < 48; c++) begin
      req_valid = (idx < 6);
      req_level = idx[0];
      pre_ready = req_ready;
      tick();
      if (req_valid && pre_ready) idx++;
      if (!req_ready && !seen_full) begin
        seen_full = 1'b1;
        acc_at_full = idx;
      end
      act = s || r;
      if (act && !prev) begin
        if (npulses < 6) plv[npulses] = s;
        if (npulses > 0 && idle_run < min_gap) min_gap = idle_run;
        npulses++;
        hi_run = 0;
      end
      if (act) hi_run++;
      else begin
        if (prev && hi_run != 1) bad_len++;
        idle_run = prev ? 1 : idle_run + 1;
      end
      prev = act;
    end
    req_valid = 1'b0;
    check32("alt_accepted", idx, 6);
    check1("alt_ready_dropped", seen_full, 1'b1);
    check32("alt_accepted_at_full", acc_at_full, 5);
    check32("alt_pulse_count", npulses, 6);
    check32("alt_pulse_levels", 32'(plv), 32'(6'b101010));
    check1("alt_min_gap_ge3", (min_gap >= 3), 1'b1);
    check32("alt_bad_pulse_len", bad_len, 0);
    check1("alt_final_qmodel", q_model, 1'b1);
    check1("alt_final_busy", busy, 1'b0);
    check32("alt_skip_unchanged", 32'(skip_cnt), 1);

    // PULSE_W=3 instance: reset in the second cycle of an s pulse.
    req_valid3 = 1'b1; req_level3 = 1'b1;
    tick();                                   // A0 accepts set
    req_level3 = 1'b0;
    tick();                                   // A0+1: pulse starts, push 0
    check1("p3_s_cycle1", s3, 1'b1);
    req_level3 = 1'b1;
    tick();                                   // A0+2: push 1, 2 queued
    req_valid3 = 1'b0;
    check1("p3_s_cycle2", s3, 1'b1);
    check1("p3_busy_pre", busy3, 1'b1);
    rst3 = 1'b1;
    #1;
    check1("p3_async_s", s3, 1'b0);
    check1("p3_async_r", r3, 1'b0);
    check1("p3_async_qmodel", q_model3, 1'b0);
    check1("p3_async_busy", busy3, 1'b0);
    check1("p3_async_ready", req_ready3, 1'b1);
    tick(); tick();
    rst3 = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (s3 || r3) pulses++;
    end
    check32("p3_no_pulses_after", pulses, 0);
    check1("p3_busy_after", busy3, 1'b0);

    // 300 level-0 requests from reset: all skipped, counter saturates.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    accepted = 0; pulses = 0;
    for (int c = 0; c < 1000 && accepted < 300; c++) begin
      req_valid = 1'b1; req_level = 1'b0;
      pre_ready = req_ready;
      tick();
      if (pre_ready) accepted++;
      if (s || r) pulses++;
    end
    req_valid = 1'b0;
    repeat (3) begin
      tick();
      if (s || r) pulses++;
    end
    check32("sat_accepted", accepted, 300);
    check32("sat_pulses", pulses, 0);
    check32("sat_skip_cnt", 32'(skip_cnt), 255);
    check1("sat_busy", busy, 1'b0);
    check1("sat_qmodel", q_model, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
